// File: rtl/multicycle_control.sv
// Control FSM for the shared-memory multicycle MIPS datapath (R-type, lw, sw, addi, beq, j).
// Latency: R/addi/sw 4 cycles, lw 5, beq/j 3 with zero-wait memory; controls decode from state + mem_ready.
// Backpressure: FETCH/MEMRD/MEMWR hold on mem_ready=0; a bounded wait turns into a sticky timeout error.
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [5:0]       opCode,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic             halted,
  output logic [1:0]       err_code
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Wait counter only ever needs to reach TIMEOUT_CYCLES-1 before the error fires.
  localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (TIMEOUT_CYCLES > 0) ? WAIT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR, S_ADDIEX,
    S_ADDIWB, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_ERROR
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_wait;
  logic              timeout;

  // A memory state stalled this cycle, and whether that stall exhausts the budget.
  always_comb begin
    mem_wait = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !mem_ready;
    timeout  = mem_wait && (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST);
  end

  // Control decode. Kept combinational: FETCH/MEMWR qualify strobes with the current
  // mem_ready, and strobes must fall the instant resetN asserts.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    halted = (state == S_IDLE);
  end

  // Sequencing, wait/timeout tracking, retired-instruction count and sticky error code.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      instr_count <= '0;
      err_code    <= 2'b00;
    end else begin
      // Any cycle that is not a stall restarts the count, so entry always starts at zero.
      wait_cnt <= mem_wait ? wait_cnt + 1'b1 : '0;
      if (instr_done)
        instr_count <= instr_count + 1'b1;
      case (state)
        S_IDLE:   if (!halt_req) state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) state <= S_DECODE;
          else if (timeout) begin
            state    <= S_ERROR;
            err_code <= 2'b10;
          end
        end
        S_DECODE: begin
          case (opCode)
            OP_RTYPE:     state <= S_EXEC;
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_ADDI:      state <= S_ADDIEX;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
            default: begin
              state    <= S_ERROR;
              err_code <= 2'b01;
            end
          endcase
        end
        S_EXEC:   state <= S_ALUWB;
        S_MEMADR: state <= (opCode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_ADDIEX: state <= S_ADDIWB;
        S_MEMRD: begin
          if (mem_ready) state <= S_MEMWB;
          else if (timeout) begin
            state    <= S_ERROR;
            err_code <= 2'b10;
          end
        end
        S_MEMWR: begin
          if (mem_ready) state <= halt_req ? S_IDLE : S_FETCH;
          else if (timeout) begin
            state    <= S_ERROR;
            err_code <= 2'b10;
          end
        end
        S_ALUWB, S_ADDIWB, S_MEMWB, S_BRANCH, S_JUMP:
          state <= halt_req ? S_IDLE : S_FETCH;
        S_ERROR:  state <= S_ERROR;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus randomized instruction stream.
// Expected controls come from a per-instruction phase script built from the opcode class.
// Every cycle compares control word, instr_done, halted, err_code and instr_count.
module tb_multicycle_control;

  localparam int TMO = 4;
  localparam int CW  = 4;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_BEQ = 6'b000100, OP_J = 6'b000010;

  // Control word: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //                RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0]}
  localparam logic [15:0] W_ZERO   = 16'h0000;
  localparam logic [15:0] W_FWAIT  = 16'h1010;
  localparam logic [15:0] W_FGO    = 16'h9410;
  localparam logic [15:0] W_DEC    = 16'h0030;
  localparam logic [15:0] W_EXEC   = 16'h0048;
  localparam logic [15:0] W_ALUWB  = 16'h0180;
  localparam logic [15:0] W_ADR    = 16'h0060;
  localparam logic [15:0] W_ADDIWB = 16'h0080;
  localparam logic [15:0] W_MEMRD  = 16'h3000;
  localparam logic [15:0] W_MEMWB  = 16'h0280;
  localparam logic [15:0] W_MEMWR  = 16'h2800;
  localparam logic [15:0] W_BRANCH = 16'h4045;
  localparam logic [15:0] W_JUMP   = 16'h8002;

  logic clk = 1'b0;
  logic resetN;
  logic [5:0] opCode;
  logic mem_ready, halt_req;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic instr_done, halted;
  logic [CW-1:0] instr_count;
  logic [1:0] err_code;
  logic [15:0] ctrl;

  int n_cmp = 0;
  int n_mis = 0;
  int cnt = 0;
  logic [1:0] exp_err = 2'b00;

  always #5 clk = ~clk;

  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                 RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  multicycle_control #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .resetN(resetN), .opCode(opCode), .mem_ready(mem_ready), .halt_req(halt_req),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .instr_done(instr_done), .instr_count(instr_count),
    .halted(halted), .err_code(err_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs just after the falling edge, check before the rising edge.
  task automatic cyc(input logic mr, input logic hr, input logic [5:0] op, input logic [15:0] ew,
                     input logic ed, input logic eidle, input string tag);
    mem_ready = mr;
    halt_req  = hr;
    opCode    = op;
    #1;
    chk({tag, ".ctrl"},   32'(ctrl), 32'(ew));
    chk({tag, ".done"},   32'(instr_done), 32'(ed));
    chk({tag, ".halted"}, 32'(halted), 32'(eidle));
    chk({tag, ".err"},    32'(err_code), 32'(exp_err));
    chk({tag, ".count"},  32'(instr_count), 32'(cnt % (1 << CW)));
    @(negedge clk);
    if (ed) cnt++;
  endtask

  task automatic idle(input logic hr);
    cyc(1'b1, hr, 6'($urandom), W_ZERO, 1'b0, 1'b1, "idle");
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    cnt = 0;
    exp_err = 2'b00;
    cyc(1'b0, 1'b0, 6'h3f, W_ZERO, 1'b0, 1'b1, "reset");
    resetN = 1'b1;
  endtask

  // Runs one legal instruction starting in FETCH; halt_req is random except on the final cycle.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic halt);
    for (int i = 0; i < fw; i++)
      cyc(1'b0, 1'($urandom), 6'($urandom), W_FWAIT, 1'b0, 1'b0, "fetch_wait");
    cyc(1'b1, 1'($urandom), 6'($urandom), W_FGO, 1'b0, 1'b0, "fetch");
    cyc(1'($urandom), 1'($urandom), op, W_DEC, 1'b0, 1'b0, "decode");
    case (op)
      OP_R: begin
        cyc(1'($urandom), 1'($urandom), op, W_EXEC, 1'b0, 1'b0, "exec");
        cyc(1'($urandom), halt, op, W_ALUWB, 1'b1, 1'b0, "aluwb");
      end
      OP_ADDI: begin
        cyc(1'($urandom), 1'($urandom), op, W_ADR, 1'b0, 1'b0, "addiex");
        cyc(1'($urandom), halt, op, W_ADDIWB, 1'b1, 1'b0, "addiwb");
      end
      OP_LW: begin
        cyc(1'($urandom), 1'($urandom), op, W_ADR, 1'b0, 1'b0, "lw_adr");
        for (int i = 0; i < mw; i++)
          cyc(1'b0, 1'($urandom), op, W_MEMRD, 1'b0, 1'b0, "memrd_wait");
        cyc(1'b1, 1'($urandom), op, W_MEMRD, 1'b0, 1'b0, "memrd");
        cyc(1'($urandom), halt, op, W_MEMWB, 1'b1, 1'b0, "memwb");
      end
      OP_SW: begin
        cyc(1'($urandom), 1'($urandom), op, W_ADR, 1'b0, 1'b0, "sw_adr");
        for (int i = 0; i < mw; i++)
          cyc(1'b0, 1'($urandom), op, W_MEMWR, 1'b0, 1'b0, "memwr_wait");
        cyc(1'b1, halt, op, W_MEMWR, 1'b1, 1'b0, "memwr");
      end
      OP_BEQ: cyc(1'($urandom), halt, op, W_BRANCH, 1'b1, 1'b0, "branch");
      default: cyc(1'($urandom), halt, op, W_JUMP, 1'b1, 1'b0, "jump");
    endcase
  endtask

  initial begin
    logic [5:0] ops [6];
    ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW;
    ops[3] = OP_ADDI; ops[4] = OP_BEQ; ops[5] = OP_J;
    resetN = 1'b0; mem_ready = 1'b0; halt_req = 1'b1; opCode = 6'h00;
    @(negedge clk);

    // Reset state, then hold in IDLE while halt_req is high, then start.
    do_reset();
    idle(1'b1);
    idle(1'b0);

    // R-type, lw with 3 wait cycles, beq then j, fetch stalled just under the timeout.
    run_instr(OP_R, 0, 0, 1'b0);
    run_instr(OP_LW, 0, 3, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b0);
    run_instr(OP_J, 0, 0, 1'b0);
    run_instr(OP_R, TMO - 1, 0, 1'b0);
    run_instr(OP_ADDI, 0, 0, 1'b0);

    // sw with halt: stop in IDLE, stay while halt_req high, restart on release.
    run_instr(OP_SW, 0, 2, 1'b1);
    idle(1'b1);
    idle(1'b0);

    // Random stream; count width is small so it wraps repeatedly.
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      logic       h;
      op = ops[$urandom_range(0, 5)];
      h  = ($urandom_range(0, 5) == 0);
      run_instr(op, $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), h);
      if (h) idle(1'b0);
    end

    // Asynchronous reset mid-FETCH: strobes and count drop before the next clock edge.
    mem_ready = 1'b0; halt_req = 1'b0;
    #1;
    chk("async.pre_memread", 32'(MemRead), 32'd1);
    #1;
    resetN = 1'b0;
    #1;
    chk("async.ctrl", 32'(ctrl), 32'(W_ZERO));
    chk("async.halted", 32'(halted), 32'd1);
    chk("async.count", 32'(instr_count), 32'd0);
    @(negedge clk);
    cnt = 0;
    exp_err = 2'b00;
    resetN = 1'b1;
    idle(1'b0);

    // Illegal opcode: ERROR with code 01, inert for 20 cycles whatever the inputs.
    cyc(1'b1, 1'b0, 6'h00, W_FGO, 1'b0, 1'b0, "ill_fetch");
    cyc(1'b1, 1'b0, 6'h3f, W_DEC, 1'b0, 1'b0, "ill_decode");
    exp_err = 2'b01;
    for (int i = 0; i < 20; i++)
      cyc(1'($urandom), 1'($urandom), 6'($urandom), W_ZERO, 1'b0, 1'b0, "ill_error");

    // Memory timeout in FETCH: four stalled cycles lead to ERROR with code 10.
    do_reset();
    idle(1'b0);
    for (int i = 0; i < TMO; i++)
      cyc(1'b0, 1'b0, 6'h00, W_FWAIT, 1'b0, 1'b0, "tmo_wait");
    exp_err = 2'b10;
    for (int i = 0; i < 5; i++)
      cyc(1'($urandom), 1'($urandom), 6'($urandom), W_ZERO, 1'b0, 1'b0, "tmo_error");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
